// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI request arbiter: FSM encoding, length-field
// sizing and the spi_master start-acknowledge timeout.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;

  localparam int BUSY_TIMEOUT = 8;
  localparam int TMR_W        = $clog2(BUSY_TIMEOUT + 1);

  // A length field must hold every value 0..depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin picker: scans requesters starting just after ptr (modulo
// NUM_REQ) and returns the first active one as a one-hot winner.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[(int'(ptr) + k + 1) % NUM_REQ]) begin
        winner[(int'(ptr) + k + 1) % NUM_REQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: grants a burst
// round-robin, copies its bytes into the master FIFO, starts the transfer
// and reports completion (or failure) with a one-cycle done/err pulse.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = len_width(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          spi_start,
  input  logic                          spi_busy,
  output arb_state_t                    state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  // Byte handshake on the requester side: a byte moves on a clock edge
  // exactly when req_valid[i] and req_ready[i] are both high; req_ready
  // never depends on req_valid, and only the granted requester sees it.

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_valid;
  logic               idle_go;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [TMR_W-1:0]   tmr;
  logic               len_bad;
  logic               in_load;
  logic               load_fire;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  // Arbitration waits out the done cycle so a requester still holding req
  // while it observes done is not granted a second time.
  assign idle_go   = pick_valid && fifo_empty && !spi_busy && (done == '0);
  assign len_bad   = (len_q == '0) || (int'(len_q) > FIFO_DEPTH);
  assign in_load   = (state == ST_LOAD) && !len_bad;
  assign load_fire = in_load && req_valid[cur] && !fifo_full;

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = load_fire;
    fifo_wr_data = '0;
    if (in_load) begin
      req_ready[cur] = !fifo_full;
      fifo_wr_data   = req_data[cur*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= PTR_RST;
      cur       <= '0;
      len_q     <= '0;
      cnt       <= '0;
      tmr       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      spi_start <= 1'b0;
    end else begin
      done      <= '0;
      err       <= 1'b0;
      spi_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_go) begin
            gnt   <= pick_oh;
            cur   <= pick_idx;
            len_q <= req_len[pick_idx*LEN_W +: LEN_W];
            cnt   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (len_bad) begin
            done  <= gnt;
            err   <= 1'b1;
            gnt   <= '0;
            ptr   <= cur;
            state <= ST_IDLE;
          end else if (load_fire) begin
            if (cnt == len_q - 1'b1) begin
              cnt       <= '0;
              spi_start <= 1'b1;
              state     <= ST_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          tmr   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (spi_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmr == TMR_W'(BUSY_TIMEOUT - 1)) begin
            done  <= gnt;
            err   <= 1'b1;
            gnt   <= '0;
            ptr   <= cur;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!spi_busy) begin
            done  <= gnt;
            gnt   <= '0;
            ptr   <= cur;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed scenarios followed by
// randomized rounds, checked against a transaction-level arbitration model.
module tb_spi_req_arbiter;
  import spi_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FD = 16;
  localparam int LW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              err;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              spi_start;
  logic              spi_busy;
  arb_state_t        state;

  spi_req_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .LEN_W      (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .spi_start    (spi_start),
    .spi_busy     (spi_busy),
    .state        (state)
  );

  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          grant_log[$];
  int          wr_cyc_q[$];
  logic [7:0]  data_mem[NR][32];
  int          len_of[NR];
  bit          never_busy[NR];
  int          byte_idx[NR];
  bit          fire_q[NR];
  bit          drop_req[NR];
  logic [NR-1:0] pending;
  int          model_ptr;
  int          cur;
  int          gnt_cyc, start_cyc, busy_fall_cyc, req_post_cyc;
  int          starts, wr_cnt;
  int          valid_pct;
  bit          rand_full;
  int          full_after, full_cnt;
  int          busy_wait, busy_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bad_len(input int len);
    return (len == 0) || (len > FD);
  endfunction

  // Next owner: first still-pending requester after the last one served.
  function automatic int model_pick();
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (model_ptr + k) % NR;
      if (pending[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  // ---------------- monitor (mid-cycle sampling) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      int exp_w;
      for (int i = 0; i < NR; i++) fire_q[i] = req_valid[i] & req_ready[i];
      if (gnt != '0 && cur < 0) begin
        exp_w = model_pick();
        check_eq("gnt_order", gnt, (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
        cur = onehot_idx(gnt);
        grant_log.push_back(cur);
        gnt_cyc = cyc;
        starts  = 0;
        wr_cnt  = 0;
        wr_cyc_q.delete();
        exp_q.delete();
        if (!bad_len(len_of[cur]))
          for (int k = 0; k < len_of[cur]; k++) exp_q.push_back(data_mem[cur][k]);
        if ($urandom_range(0, 2) == 0) drop_req[cur] = 1'b1;
      end
      if (req_ready != '0)
        check_eq("ready_owner", req_ready, (cur < 0) ? 32'd0 : (32'd1 << cur));
      if (fifo_full) begin
        check_eq("wr_while_full", fifo_wr_en, 0);
        check_eq("ready_while_full", req_ready, 0);
      end
      if (fifo_wr_en) begin
        wr_cnt++;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check_eq("wr_unexpected", 1, 0);
        else check_eq("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      if (spi_start) begin
        starts++;
        start_cyc = cyc;
        if (cur >= 0 && !never_busy[cur]) busy_wait = $urandom_range(1, 5);
      end
      if (done != '0) begin
        if (cur < 0) begin
          check_eq("done_unexpected", done, 0);
        end else begin
          check_eq("done_who", done, 32'd1 << cur);
          check_eq("err_flag", err, bad_len(len_of[cur]) || never_busy[cur]);
          check_eq("gnt_clear_at_done", gnt, 0);
          check_eq("bytes_left", exp_q.size(), 0);
          check_eq("start_count", starts, bad_len(len_of[cur]) ? 0 : 1);
          if (bad_len(len_of[cur]))  check_eq("badlen_done_lat", cyc - gnt_cyc, 1);
          else if (never_busy[cur])  check_eq("timeout_lat", cyc - start_cyc, BUSY_TIMEOUT + 1);
          else                       check_eq("done_after_busy", cyc - busy_fall_cyc, 1);
          pending[cur]  = 1'b0;
          model_ptr     = cur;
          drop_req[cur] = 1'b1;
          cur           = -1;
        end
      end else if (err) begin
        check_eq("err_without_done", err, 0);
      end
    end
  end

  // ---------------- drivers: requesters, FIFO status, spi_master ----------------
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (fire_q[i]) begin
          byte_idx[i]++;
          fire_q[i] = 1'b0;
        end
        if (drop_req[i]) begin
          req[i]      = 1'b0;
          drop_req[i] = 1'b0;
        end
        if (pending[i] && byte_idx[i] < len_of[i] && $urandom_range(0, 99) < valid_pct) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = data_mem[i][byte_idx[i]];
        end else begin
          req_valid[i]          = 1'b0;
          req_data[i*DW +: DW]  = 8'($urandom);
        end
      end
      if (full_after >= 0 && cur >= 0 && wr_cnt == full_after) begin
        full_cnt   = 3;
        full_after = -1;
      end else if (rand_full && cur >= 0 && full_cnt == 0 && $urandom_range(0, 7) == 0) begin
        full_cnt = $urandom_range(1, 3);
      end
      if (full_cnt > 0) begin
        fifo_full = 1'b1;
        full_cnt--;
      end else begin
        fifo_full = 1'b0;
      end
      if (busy_wait > 0) begin
        busy_wait--;
        if (busy_wait == 0) begin
          spi_busy = 1'b1;
          busy_len = $urandom_range(1, 6);
        end
      end else if (spi_busy) begin
        busy_len--;
        if (busy_len == 0) begin
          spi_busy      = 1'b0;
          busy_fall_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_bench();
    pending   = '0;
    cur       = -1;
    model_ptr = NR - 1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      fire_q[i]   = 1'b0;
      drop_req[i] = 1'b0;
      byte_idx[i] = 0;
      len_of[i]   = 1;
      never_busy[i] = 1'b0;
    end
    req        = '0;
    req_valid  = '0;
    req_len    = '0;
    req_data   = '0;
    busy_wait  = 0;
    busy_len   = 0;
    spi_busy   = 1'b0;
    full_cnt   = 0;
    full_after = -1;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    rand_full  = 1'b0;
    valid_pct  = 100;
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int i, input int len, input bit never);
    len_of[i]     = len;
    never_busy[i] = never;
    for (int k = 0; k < 32; k++) data_mem[i][k] = 8'($urandom);
    req_len[i*LW +: LW] = LW'(len);
    byte_idx[i]   = 0;
    pending[i]    = 1'b1;
    req[i]        = 1'b1;
    req_post_cyc  = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pending != '0 || cur >= 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check_eq("burst_timeout", pending, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_start"}, spi_start, 0);
    check_eq({tag, "_wr_en"}, fifo_wr_en, 0);
    check_eq({tag, "_ready"}, req_ready, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    clear_bench();
    repeat (3) @(posedge clk);
    #2;
    check_quiet("rst");
    check_eq("rst_state", state, ST_IDLE);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Two requesters at once, twice: order follows the rotating pointer.
    grant_log.delete();
    sync(); post(0, 1, 0); post(2, 1, 0); wait_idle(500);
    sync(); post(0, 1, 0); post(2, 1, 0); wait_idle(500);
    check_eq("rr_log_size", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check_eq("rr_g0", grant_log[0], 0);
      check_eq("rr_g1", grant_log[1], 2);
      check_eq("rr_g2", grant_log[2], 0);
      check_eq("rr_g3", grant_log[3], 2);
    end

    // Two-byte burst with valid held: back-to-back writes, minimum latency.
    sync();
    post(0, 2, 0);
    data_mem[0][0] = 8'hA5;
    data_mem[0][1] = 8'h3C;
    wait_idle(500);
    check_eq("s1_writes", wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2) begin
      check_eq("s1_back_to_back", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check_eq("s1_latency", wr_cyc_q[0] + 1 - req_post_cyc, 2);
    end

    // FIFO full for three cycles in the middle of a six-byte load.
    sync(); full_after = 2; post(1, 6, 0); wait_idle(500);
    check_eq("s3_writes", wr_cyc_q.size(), 6);

    // Illegal lengths, then a master that never reports busy.
    sync(); post(2, 0, 0);  wait_idle(200);
    sync(); post(3, 17, 0); wait_idle(200);
    sync(); post(1, 3, 1);  wait_idle(500);

    // Reset in the middle of a load; req[0] must win afterwards.
    sync(); post(0, 1, 0); wait_idle(200);
    sync(); post(1, 8, 0);
    begin
      int n = 0;
      while (wr_cnt < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("s6_reach_load", n < 100, 1);
    end
    sync();
    check_eq("s6_mid_load", state, ST_LOAD);
    rst = 1'b1;
    #1;
    check_quiet("s6_rst");
    clear_bench();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    grant_log.delete();
    sync(); post(1, 2, 0); post(0, 2, 0); wait_idle(500);
    check_eq("s6_first_after_rst", (grant_log.size() > 0) ? grant_log[0] : 99, 0);

    // No grant while the master FIFO still holds data.
    sync();
    fifo_empty = 1'b0;
    post(3, 1, 0);
    repeat (6) @(posedge clk);
    #2;
    check_eq("no_gnt_fifo_not_empty", gnt, 0);
    fifo_empty = 1'b1;
    wait_idle(300);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      sync();
      valid_pct = $urandom_range(40, 100);
      rand_full = 1'b1;
      begin
        logic [NR-1:0] mask;
        mask = NR'($urandom_range(1, (1 << NR) - 1));
        for (int i = 0; i < NR; i++) begin
          if (mask[i]) begin
            int sel, len;
            sel = $urandom_range(0, 19);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(FD + 1, 31);
            else               len = $urandom_range(1, FD);
            post(i, len, $urandom_range(0, 9) == 0);
          end
        end
      end
      wait_idle(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
